// File: rtl/writeback_pc.sv
// Write-back / PC-update stage of the sequential Y86-64 core: register file,
// next-PC register, sticky status FSM and retired-instruction counter.
module writeback_pc #(
  parameter logic [63:0] RESET_PC = 64'd64,
  parameter logic [63:0] RSP_INIT = 64'd0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic             cnd,
  input  logic [63:0]      valC,
  input  logic [63:0]      valP,
  input  logic [63:0]      valE,
  input  logic [63:0]      valM,
  input  logic             imem_error,
  input  logic             instr_valid,
  input  logic             dmem_error,
  output logic [63:0]      valA,
  output logic [63:0]      valB,
  output logic [63:0]      PC,
  output logic [2:0]       stat,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_AOK = 3'd1,
    S_HLT = 3'd2,
    S_ADR = 3'd3,
    S_INS = 3'd4
  } stat_t;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  logic [63:0]      regs_q [15];
  logic [63:0]      regs_d [15];
  logic [63:0]      pc_q, pc_d;
  stat_t            stat_q, stat_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [3:0]       src_a, src_b, dst_e, dst_m;
  logic             commit;
  logic [63:0]      next_pc;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    unique case (icode)
      4'h2, 4'h4, 4'h6, 4'hA: src_a = rA;
      4'h9, 4'hB:             src_a = RSP;
      default:                src_a = RNONE;
    endcase
    unique case (icode)
      4'h4, 4'h5, 4'h6:       src_b = rB;
      4'h8, 4'h9, 4'hA, 4'hB: src_b = RSP;
      default:                src_b = RNONE;
    endcase
    unique case (icode)
      4'h3, 4'h6:             dst_e = rB;
      4'h2:                   dst_e = cnd ? rB : RNONE;
      4'h8, 4'h9, 4'hA, 4'hB: dst_e = RSP;
      default:                dst_e = RNONE;
    endcase
    unique case (icode)
      4'h5, 4'hB:             dst_m = rA;
      default:                dst_m = RNONE;
    endcase
  end

  // Reads see pre-edge contents only; there is deliberately no write bypass.
  always_comb begin
    valA = (src_a == RNONE) ? 64'd0 : regs_q[src_a];
    valB = (src_b == RNONE) ? 64'd0 : regs_q[src_b];
  end

  always_comb begin
    unique case (icode)
      4'h7:    next_pc = cnd ? valC : valP;
      4'h8:    next_pc = valC;
      4'h9:    next_pc = valM;
      default: next_pc = valP;
    endcase
  end

  // Faults and halts are evaluated before commit, so the offending
  // instruction leaves registers, PC and counter untouched.
  always_comb begin
    stat_d = stat_q;
    commit = 1'b0;
    unique case (stat_q)
      S_AOK: begin
        if (imem_error || dmem_error) stat_d = S_ADR;
        else if (!instr_valid)        stat_d = S_INS;
        else if (icode == 4'h0)       stat_d = S_HLT;
        else                          commit = 1'b1;
      end
      default: stat_d = stat_q;
    endcase
  end

  // valM is written after valE so it wins on dstE==dstM (popq %rsp).
  always_comb begin
    for (int i = 0; i < 15; i++) regs_d[i] = regs_q[i];
    pc_d      = pc_q;
    retired_d = retired_q;
    if (commit) begin
      if (dst_e != RNONE) regs_d[dst_e] = valE;
      if (dst_m != RNONE) regs_d[dst_m] = valM;
      pc_d      = next_pc;
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) regs_q[i] <= (i == 4) ? RSP_INIT : 64'd0;
      pc_q      <= RESET_PC;
      stat_q    <= S_AOK;
      retired_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pc_q      <= pc_d;
      stat_q    <= stat_d;
      retired_q <= retired_d;
    end
  end

  assign PC      = pc_q;
  assign stat    = stat_q;
  assign retired = retired_q;

endmodule

// File: doc/writeback_pc.md
Name: writeback_pc

Overview:
- Architectural-state stage of the sequential Y86-64 core. It sits directly downstream of the memory stage and closes the loop back to fetch and decode.
- Holds the 15-entry register file. Serves decode's two read ports combinationally.
- Writes back valE and valM on the rising clock edge.
- Computes and registers the next PC.
- Maintains a sticky processor status FSM and a retired-instruction counter.

Parameters:
RESET_PC, 64, PC value loaded on reset
RSP_INIT, 0, value of register 4 (%rsp) after reset
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
icode  in  4  instruction code from fetch
rA  in  4  register specifier A from fetch
rB  in  4  register specifier B from fetch
cnd  in  1  condition result from execute
valC  in  64  constant from fetch
valP  in  64  fall-through PC from fetch
valE  in  64  execute result
valM  in  64  memory read data
imem_error  in  1  fetch address invalid (fetch valid_memory deasserted)
instr_valid  in  1  fetch decoded a legal icode/ifun
dmem_error  in  1  data-memory address error from memory stage
valA  out  64  read data for srcA, combinational
valB  out  64  read data for srcB, combinational
PC  out  64  current program counter, registered
stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
retired  out  CNT_W  count of instructions committed

Behaviour:
- The clock is one rising-edge clock. Reset is asynchronous and active-low, named rst_n.
- Reset values while rst_n=0:
  - PC=RESET_PC, stat=AOK (1), retired=0.
  - Registers 0-14 = 0, except register 4 = RSP_INIT.
  - Reset takes effect immediately, with no clock needed. The first edge after release executes the instruction at RESET_PC.
- Source selection (combinational):
  - srcA = rA for icode 2, 4, 6, A; 4 for icode 9, B; else F.
  - srcB = rB for icode 4, 5, 6; 4 for icode 8, 9, A, B; else F.
  - valA/valB = reg[src]. Source F reads 0.
  - Reads reflect pre-edge contents. A write becomes visible only after the edge, with no bypass.
- Destination selection:
  - dstE = rB for icode 3, 6, and for icode 2 when cnd=1. icode 2 with cnd=0 gives F.
  - dstE = 4 for icode 8, 9, A, B; else F.
  - dstM = rA for icode 5, B; else F.
- Write rules:
  - Writes of register F are discarded.
  - When dstE==dstM and the register is not F, valM wins (popq %rsp loads the popped value).
- Next PC:
  - icode 7: cnd ? valC : valP.
  - icode 8: valC.
  - icode 9: valM.
  - Otherwise: valP.
  - Arithmetic is full 64-bit, with no wrap checks.
- Status FSM, 4 states AOK, HLT, ADR, INS:
  - From AOK, each edge evaluates the incoming instruction with priority ADR > INS > HLT.
    - imem_error or dmem_error → ADR.
    - else !instr_valid → INS.
    - else icode==0 → HLT.
    - else stay AOK.
  - HLT, ADR and INS are absorbing and are left only by reset.
  - The faulting or halting instruction commits nothing: no register write and no PC change. PC stays at the halt or fault address, and retired does not increment.
- Commit:
  - In AOK with no fault, each edge performs the register writes, loads PC with the next PC, and increments retired.
  - retired wraps at 2^CNT_W to 0.
  - Outside AOK, all state is frozen except through reset.
- Reset asserted mid-cycle between edges overrides any pending commit.
- Outputs carry no X while in reset.

Test Plan:
1. Reset with RESET_PC=64, RSP_INIT=0x100 → PC=64, stat=1, retired=0, valB with icode=A equals 0x100. Release reset → first edge commits the instruction at 64.
2. irmovq (icode 3, rB=3, valE=31, valP=76) → after edge reg3=31, PC=76, retired=1. Same-cycle read of reg3 before the edge returns the old value 0.
3. cmovxx (icode 2, rB=3, valE=7): cnd=0 → reg3 unchanged. cnd=1 → reg3=7.
4. popq %rsp (icode B, rA=4, valE=0x108, valM=0x55) → reg4=0x55 (M wins over E). jXX with cnd=1, valC=0x200 → PC=0x200; with cnd=0 → PC=valP. ret with valM=0x80 → PC=0x80.
5. halt (icode 0) at PC=101 → stat=2, PC stays 101, retired unchanged. A following irmovq stimulus changes no register.
6. Simultaneous dmem_error=1 and instr_valid=0 → stat=3 (ADR priority), no write. Then pulse rst_n low between edges → stat=1 and PC=RESET_PC immediately. With CNT_W=4, retire 16 instructions → retired wraps to 0.
